imem_loader: RTL and testbench

- Boot-time writer for the instruction ROM/RAM: accepts a byte stream from a UART receiver or debug bridge, assembles little-endian 32-bit words, and issues word writes into the instruction memory array.
- It is the write side of the CPU's read-only instruction-fetch port: same word-aligned byte addressing (word index = addr[ADDR_WIDTH+1:2]) and the same 32-bit data.
- Holds the CPU in reset while loading and releases it on success.

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_loader_byte_to_word.sv | 50 +++++
 rtl/imem_loader.sv | 176 +++++++++++++++++
 tb/tb_imem_loader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and the fetch ROM.
// Both ends import the word-address width and base address from here so
// they agree on the memory geometry.
package imem_pkg;

    localparam int          IMEM_ADDR_WIDTH = 12;
    localparam logic [31:0] IMEM_BASE_ADDR  = 32'h0000_0000;
    localparam int          IMEM_WORDS      = 2 ** IMEM_ADDR_WIDTH;

    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_to_word.sv
// byte_to_word: assembles four bytes into a little-endian 32-bit word.
// The first byte lands in [7:0]. 'last' and 'word_next' are combinational
// views of the byte being accepted, so the parent can act on the 4th byte
// in the same cycle. 'word'/'word_valid' are the registered result; the
// pulse only fires for words the parent marks with 'capture'.
module byte_to_word (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        capture,
    input  logic [7:0]  data,
    output logic        last,
    output logic [31:0] word_next,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt_reg;
    logic [23:0] shift_reg;
    logic [31:0] word_reg;
    logic        word_valid_reg;

    assign last       = en && (cnt_reg == 2'd3);
    assign word_next  = {data, shift_reg};
    assign word       = word_reg;
    assign word_valid = word_valid_reg;

    // Byte counter, partial-word shifter and registered word/strobe.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg        <= 2'd0;
            shift_reg      <= 24'd0;
            word_valid_reg <= 1'b0;
            if (rst) begin
                word_reg <= 32'd0;
            end
        end else begin
            word_valid_reg <= last && capture;
            if (en) begin
                cnt_reg   <= cnt_reg + 2'd1;
                shift_reg <= {data, shift_reg[23:8]};
            end
            if (last) begin
                word_reg <= word_next;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory. Receives a
// length-prefixed byte frame, assembles little-endian words and writes
// them at BASE_ADDR + 4*index, holding the CPU in reset until the load
// completes. Define IMEM_LOADER_CHECKSUM_EN to require a trailing
// modulo-256 checksum byte over the payload.
module imem_loader
    import imem_pkg::*;
#(
    parameter int          ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter logic [31:0] BASE_ADDR  = IMEM_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

    loader_state_t       state_reg;
    logic [ADDR_WIDTH:0] word_idx_reg;
    logic [ADDR_WIDTH:0] word_idx_inc;
    logic [31:0]         len_reg;
    logic [31:0]         mem_addr_reg;
    logic                in_ready_reg;
    logic                cpu_hold_reg;
    logic                done_reg;
    logic                error_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          sum_reg;
`endif

    logic        accept;
    logic        restart;
    logic        b2w_en;
    logic        b2w_capture;
    logic        b2w_last;
    logic [31:0] b2w_word_next;

    // in_ready depends on state only; a word write never back-pressures
    // the stream, so bytes keep flowing while mem_we is high.
    assign accept       = in_valid && in_ready_reg;
    assign restart      = start && (state_reg == ST_DONE || state_reg == ST_ERR);
    assign b2w_en       = accept && (state_reg == ST_LEN || state_reg == ST_DATA);
    assign b2w_capture  = (state_reg == ST_DATA);
    assign word_idx_inc = word_idx_reg + {{ADDR_WIDTH{1'b0}}, 1'b1};

    assign in_ready = in_ready_reg;
    assign mem_addr = mem_addr_reg;
    assign cpu_hold = cpu_hold_reg;
    assign done     = done_reg;
    assign error    = error_reg;

    byte_to_word u_b2w (
        .clk        (clk),
        .rst        (rst),
        .clr        (restart),
        .en         (b2w_en),
        .capture    (b2w_capture),
        .data       (in_data),
        .last       (b2w_last),
        .word_next  (b2w_word_next),
        .word       (mem_wdata),
        .word_valid (mem_we)
    );

    // Loader FSM; every output flag is registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_LEN;
            word_idx_reg <= '0;
            len_reg      <= 32'd0;
            mem_addr_reg <= BASE_ADDR;
            in_ready_reg <= 1'b1;
            cpu_hold_reg <= 1'b1;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_reg      <= 8'd0;
`endif
        end else begin
            case (state_reg)
                ST_LEN: begin
                    if (accept && b2w_last) begin
                        len_reg <= b2w_word_next;
                        if (b2w_word_next > CAPACITY) begin
                            state_reg    <= ST_ERR;
                            error_reg    <= 1'b1;
                            in_ready_reg <= 1'b0;
                        end else if (b2w_word_next == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_reg    <= ST_CSUM;
`else
                            state_reg    <= ST_DONE;
                            done_reg     <= 1'b1;
                            cpu_hold_reg <= 1'b0;
                            in_ready_reg <= 1'b0;
`endif
                        end else begin
                            state_reg <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_reg <= sum_reg + in_data;
`endif
                        if (b2w_last) begin
                            mem_addr_reg <= BASE_ADDR + 32'({word_idx_reg, 2'b00});
                            word_idx_reg <= word_idx_inc;
                            if (32'(word_idx_inc) == len_reg) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_reg    <= ST_CSUM;
`else
                                state_reg    <= ST_DONE;
                                done_reg     <= 1'b1;
                                cpu_hold_reg <= 1'b0;
                                in_ready_reg <= 1'b0;
`endif
                            end
                        end
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (accept) begin
                        in_ready_reg <= 1'b0;
                        if (in_data == sum_reg) begin
                            state_reg    <= ST_DONE;
                            done_reg     <= 1'b1;
                            cpu_hold_reg <= 1'b0;
                        end else begin
                            state_reg <= ST_ERR;
                            error_reg <= 1'b1;
                        end
                    end
                end
`endif

                ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_reg    <= ST_LEN;
                        word_idx_reg <= '0;
                        len_reg      <= 32'd0;
                        mem_addr_reg <= BASE_ADDR;
                        in_ready_reg <= 1'b1;
                        cpu_hold_reg <= 1'b1;
                        done_reg     <= 1'b0;
                        error_reg    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_reg      <= 8'd0;
`endif
                    end
                end

                default: begin
                    state_reg    <= ST_ERR;
                    error_reg    <= 1'b1;
                    in_ready_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader (BASE_ADDR = 0x100). Adapts its expectations
// to whether IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
    import imem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    localparam logic [31:0] BASE = 32'h0000_0100;

    imem_loader #(.ADDR_WIDTH(IMEM_ADDR_WIDTH), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int wr_count = 0;

    // Count every write strobe seen between clock edges.
    always @(negedge clk) begin
        if (mem_we === 1'b1) wr_count++;
    end

    typedef struct {
        string           name;
        logic [31:0]     len;
        logic [2:0][31:0] w;
        logic [7:0]      csum;
        bit              err_on;
        bit              err_off;
        int              gap;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one byte from a negedge; returns at the negedge after it transfers.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 16; t++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Pulse start from DONE/ERR, optionally with a byte offered the same cycle.
    task automatic restart(input bit with_byte);
        @(negedge clk);
        start    = 1'b1;
        in_valid = with_byte;
        in_data  = 8'hFF;
        check("restart_in_ready_low", in_ready, 1'b0);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        check("restart_done_clr", done, 1'b0);
        check("restart_error_clr", error, 1'b0);
        check("restart_hold", cpu_hold, 1'b1);
        check("restart_in_ready", in_ready, 1'b1);
    endtask

    task automatic apply(input vec_t v);
        bit ok;
        int base_wr;
        int nw;
        bit exp_err;
        base_wr = wr_count;
        nw      = (v.len > 32'(IMEM_WORDS)) ? 0 : int'(v.len);
        exp_err = CSUM_ON ? v.err_on : v.err_off;
        for (int b = 0; b < 4; b++) begin
            send_byte(v.len[8*b +: 8], v.gap, ok);
            check({v.name, "_len_accept"}, ok, 1'b1);
        end
        if (nw > 0) check({v.name, "_hold_loading"}, cpu_hold, 1'b1);
        for (int i = 0; i < nw; i++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(v.w[i][8*b +: 8], v.gap, ok);
                check({v.name, "_data_accept"}, ok, 1'b1);
                if (b == 3) begin
                    check({v.name, "_we"}, mem_we, 1'b1);
                    check({v.name, "_addr"}, mem_addr, BASE + 32'(4 * i));
                    check({v.name, "_wdata"}, mem_wdata, v.w[i]);
                end else begin
                    check({v.name, "_we_idle"}, mem_we, 1'b0);
                end
            end
        end
        if (CSUM_ON && v.len <= 32'(IMEM_WORDS)) begin
            send_byte(v.csum, v.gap, ok);
            check({v.name, "_csum_accept"}, ok, 1'b1);
        end
        check({v.name, "_error"}, error, exp_err);
        check({v.name, "_done"}, done, !exp_err);
        check({v.name, "_cpu_hold"}, cpu_hold, exp_err);
        check({v.name, "_in_ready"}, in_ready, 1'b0);
        @(negedge clk);
        #1;
        check({v.name, "_write_count"}, wr_count - base_wr, nw);
        $display("vector %s len=%0d writes=%0d done=%b error=%b cpu_hold=%b",
                 v.name, v.len, wr_count - base_wr, done, error, cpu_hold);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   ok;
        vec_t rv;
        int   base_wr;
        logic [31:0] cap;

        vecs[0] = '{"basic",     32'd2,      {32'h0, 32'hDEADBEEF, 32'h12345678}, 8'h4C, 1'b0, 1'b0, 0};
        vecs[1] = '{"bad_csum",  32'd2,      {32'h0, 32'hDEADBEEF, 32'h12345678}, 8'h00, 1'b1, 1'b0, 1};
        vecs[2] = '{"oversize",  32'h1001,   {32'h0, 32'h0, 32'h0},               8'h00, 1'b1, 1'b1, 0};
        vecs[3] = '{"zero_len",  32'd0,      {32'h0, 32'h0, 32'h0},               8'h00, 1'b0, 1'b0, 2};
        vecs[4] = '{"three",     32'd3,      {32'hCAFEF00D, 32'h07060504, 32'h03020100}, 8'hE1, 1'b0, 1'b0, 1};
        vecs[5] = '{"bad_one",   32'd1,      {32'h0, 32'h0, 32'hA5A5A5A5},        8'h95, 1'b1, 1'b0, 0};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, BASE);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_cpu_hold", cpu_hold, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;

        // start outside DONE/ERR is ignored
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("start_in_len_ready", in_ready, 1'b1);
        check("start_in_len_done", done, 1'b0);

        for (int i = 0; i < 6; i++) begin
            apply(vecs[i]);
            restart(i[0]);
        end

        // Length exactly at capacity is accepted into DATA.
        cap = 32'(IMEM_WORDS);
        for (int b = 0; b < 4; b++) begin
            send_byte(cap[8*b +: 8], 0, ok);
            check("cap_len_accept", ok, 1'b1);
        end
        check("cap_no_error", error, 1'b0);
        check("cap_in_ready", in_ready, 1'b1);
        check("cap_hold", cpu_hold, 1'b1);

        // One full word, then a partial word interrupted by reset.
        base_wr = wr_count;
        for (int b = 0; b < 4; b++) send_byte(8'h11 + 8'(b * 17), 0, ok);
        check("mid_we", mem_we, 1'b1);
        check("mid_addr", mem_addr, BASE);
        check("mid_wdata", mem_wdata, 32'h44332211);
        send_byte(8'h55, 0, ok);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_data_ready", in_ready, 1'b1);
        check("start_in_data_error", error, 1'b0);
        send_byte(8'h66, 0, ok);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_we", mem_we, 1'b0);
        check("midrst_addr", mem_addr, BASE);
        check("midrst_ready", in_ready, 1'b1);
        @(negedge clk);
        #1;
        check("midrst_partial_not_written", wr_count - base_wr, 1);
        @(negedge clk);

        rv = '{"reload", 32'd1, {32'h0, 32'h0, 32'hA1B2C3D4}, 8'hEA, 1'b0, 1'b0, 0};
        apply(rv);
        restart(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
